// File: rtl/axi4_instr_seq_if.sv
// AXI4-Stream word channel for the DDR4 instruction sequencer.
// Carries packed instruction words with a valid/ready handshake.
interface axi4_instr_seq_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axi4_instr_seq.sv
// DDR4 instruction sequencer: buffers packed command words in a FIFO and
// issues one decoded word per cycle, with WAIT stalls and status counters.
module axi4_instr_seq #(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_WIDTH = 32,
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int COL_WIDTH  = 10,
  parameter int ROW_WIDTH  = 17,
  parameter int WAIT_WIDTH = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32,
  localparam int DW = NUM_SLOTS * SLOT_WIDTH,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  axi4_instr_seq_if.slave                 s_axis,
  input  logic                            enable,
  output logic [NUM_SLOTS-1:0]            ddr_write,
  output logic [NUM_SLOTS-1:0]            ddr_read,
  output logic [NUM_SLOTS-1:0]            ddr_pre,
  output logic [NUM_SLOTS-1:0]            ddr_act,
  output logic [NUM_SLOTS-1:0]            ddr_ref,
  output logic [NUM_SLOTS-1:0]            ddr_zq,
  output logic [NUM_SLOTS-1:0]            ddr_nop,
  output logic [NUM_SLOTS-1:0]            ddr_ap,
  output logic [NUM_SLOTS-1:0]            ddr_half_bl,
  output logic [NUM_SLOTS-1:0]            ddr_pall,
  output logic [NUM_SLOTS*BG_WIDTH-1:0]   ddr_bg,
  output logic [NUM_SLOTS*BANK_WIDTH-1:0] ddr_bank,
  output logic [NUM_SLOTS*COL_WIDTH-1:0]  ddr_col,
  output logic [NUM_SLOTS*ROW_WIDTH-1:0]  ddr_row,
  output logic [LW-1:0]                   fifo_level,
  output logic [CNT_WIDTH-1:0]            underflow_cnt,
  output logic [CNT_WIDTH-1:0]            issued_cnt,
  output logic [2:0]                      latest_instr_id
);

  localparam int F = 3 + BANK_WIDTH + BG_WIDTH;

  if (F + ROW_WIDTH > SLOT_WIDTH) begin : g_bad_row
    $error("row field does not fit in slot");
  end
  if (F + COL_WIDTH + 2 > SLOT_WIDTH) begin : g_bad_col
    $error("column/ap/half_bl fields do not fit in slot");
  end
  if (3 + WAIT_WIDTH > SLOT_WIDTH) begin : g_bad_wait
    $error("wait count does not fit in slot");
  end

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PRE  = 3'd1;
  localparam logic [2:0] OP_ACT  = 3'd2;
  localparam logic [2:0] OP_RD   = 3'd3;
  localparam logic [2:0] OP_WR   = 3'd4;
  localparam logic [2:0] OP_REF  = 3'd5;
  localparam logic [2:0] OP_WAIT = 3'd6;
  localparam logic [2:0] OP_ZQ   = 3'd7;

  typedef enum logic {
    S_RUN,
    S_WAIT
  } state_t;

  state_t                state;
  logic [WAIT_WIDTH-1:0] wcnt;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [DW-1:0] head;
  logic          push;
  logic          pop;

  assign s_axis.tready = (level < LW'(FIFO_DEPTH));
  assign push = s_axis.tvalid && s_axis.tready;
  assign pop = (state == S_RUN) && enable && (level != '0);
  assign head = mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis.tdata;
  end

  logic [2:0]            head_op;
  logic [WAIT_WIDTH-1:0] wait_n;
  logic [WAIT_WIDTH-1:0] wait_load;
  logic                  unused_bits;

  assign head_op = head[2:0];
  assign wait_n = head[3 +: WAIT_WIDTH];
  assign wait_load = (wait_n == '0) ? '0 : wait_n - 1'b1;
  assign unused_bits = ^head;

  logic [NUM_SLOTS-1:0]            d_write, d_read, d_pre, d_act, d_ref;
  logic [NUM_SLOTS-1:0]            d_zq, d_nop, d_ap, d_half_bl, d_pall;
  logic [NUM_SLOTS*BG_WIDTH-1:0]   d_bg;
  logic [NUM_SLOTS*BANK_WIDTH-1:0] d_bank;
  logic [NUM_SLOTS*COL_WIDTH-1:0]  d_col;
  logic [NUM_SLOTS*ROW_WIDTH-1:0]  d_row;
  logic [SLOT_WIDTH-1:0]           slot;
  logic [2:0]                      op;

  always_comb begin
    d_write   = '0;
    d_read    = '0;
    d_pre     = '0;
    d_act     = '0;
    d_ref     = '0;
    d_zq      = '0;
    d_nop     = '0;
    d_ap      = '0;
    d_half_bl = '0;
    d_pall    = '0;
    d_bg      = '0;
    d_bank    = '0;
    d_col     = '0;
    d_row     = '0;
    slot      = '0;
    op        = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot = head[i*SLOT_WIDTH +: SLOT_WIDTH];
      op   = slot[2:0];
      d_bank[i*BANK_WIDTH +: BANK_WIDTH] = slot[3 +: BANK_WIDTH];
      d_bg[i*BG_WIDTH +: BG_WIDTH]       = slot[3+BANK_WIDTH +: BG_WIDTH];
      d_row[i*ROW_WIDTH +: ROW_WIDTH]    = slot[F +: ROW_WIDTH];
      d_col[i*COL_WIDTH +: COL_WIDTH]    = slot[F +: COL_WIDTH];
      // WAIT outside slot 0 has no timing meaning and issues as NOP
      unique case (1'b1)
        (op == OP_NOP),
        (op == OP_WAIT): d_nop[i] = 1'b1;
        (op == OP_PRE): begin
          d_pre[i]  = 1'b1;
          d_pall[i] = slot[F];
        end
        (op == OP_ACT): d_act[i] = 1'b1;
        (op == OP_RD): begin
          d_read[i]    = 1'b1;
          d_ap[i]      = slot[F+COL_WIDTH];
          d_half_bl[i] = slot[F+COL_WIDTH+1];
        end
        (op == OP_WR): begin
          d_write[i]   = 1'b1;
          d_ap[i]      = slot[F+COL_WIDTH];
          d_half_bl[i] = slot[F+COL_WIDTH+1];
        end
        (op == OP_REF): d_ref[i] = 1'b1;
        (op == OP_ZQ): d_zq[i] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_RUN;
      wcnt            <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level           <= '0;
      underflow_cnt   <= '0;
      issued_cnt      <= '0;
      latest_instr_id <= '0;
      ddr_write       <= '0;
      ddr_read        <= '0;
      ddr_pre         <= '0;
      ddr_act         <= '0;
      ddr_ref         <= '0;
      ddr_zq          <= '0;
      ddr_nop         <= '0;
      ddr_ap          <= '0;
      ddr_half_bl     <= '0;
      ddr_pall        <= '0;
      ddr_bg          <= '0;
      ddr_bank        <= '0;
      ddr_col         <= '0;
      ddr_row         <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      ddr_write   <= '0;
      ddr_read    <= '0;
      ddr_pre     <= '0;
      ddr_act     <= '0;
      ddr_ref     <= '0;
      ddr_zq      <= '0;
      ddr_nop     <= '1;
      ddr_ap      <= '0;
      ddr_half_bl <= '0;
      ddr_pall    <= '0;
      ddr_bg      <= '0;
      ddr_bank    <= '0;
      ddr_col     <= '0;
      ddr_row     <= '0;

      unique case (state)
        S_RUN: begin
          if (enable && level == '0) begin
            if (underflow_cnt != '1)
              underflow_cnt <= underflow_cnt + 1'b1;
          end else if (pop && head_op == OP_WAIT) begin
            // the pop cycle is the first idle cycle of the stall
            if (wait_load != '0) begin
              state <= S_WAIT;
              wcnt  <= wait_load;
            end
          end else if (pop) begin
            ddr_write       <= d_write;
            ddr_read        <= d_read;
            ddr_pre         <= d_pre;
            ddr_act         <= d_act;
            ddr_ref         <= d_ref;
            ddr_zq          <= d_zq;
            ddr_nop         <= d_nop;
            ddr_ap          <= d_ap;
            ddr_half_bl     <= d_half_bl;
            ddr_pall        <= d_pall;
            ddr_bg          <= d_bg;
            ddr_bank        <= d_bank;
            ddr_col         <= d_col;
            ddr_row         <= d_row;
            latest_instr_id <= head_op;
            if (issued_cnt != '1)
              issued_cnt <= issued_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (enable) begin
            if (wcnt <= 1) begin
              state <= S_RUN;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt - 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/axi4_instr_seq.md
Name: axi4_instr_seq

Overview:
- Parametrised successor to the AXI4-Stream DDR4 instruction decoder.
- Accepts packed instruction words of NUM_SLOTS slots over AXI4-Stream and buffers them in a FIFO, with real backpressure.
- Issues one decoded word per cycle to the DDR4 adapter. Adds an enable gate, a multi-cycle WAIT instruction, ZQ decode, separate AP/half-BL fields, and underflow/issue counters.

Parameters:
NUM_SLOTS, 4, commands per word (one per DDR4 command slot)
SLOT_WIDTH, 32, bits per slot
BG_WIDTH, 2, bank-group bits
BANK_WIDTH, 2, bank bits
COL_WIDTH, 10, column bits
ROW_WIDTH, 17, row bits
WAIT_WIDTH, 16, WAIT count bits
FIFO_DEPTH, 16, words buffered; power of two, >=2
CNT_WIDTH, 32, status counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
S_AXIS_TDATA  in  NUM_SLOTS*SLOT_WIDTH  packed instruction word; slot i at [i*SLOT_WIDTH +: SLOT_WIDTH]
S_AXIS_TVALID  in  1  word valid
S_AXIS_TREADY  out  1  FIFO can accept
enable  in  1  issue enable
ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop, ddr_ap, ddr_half_bl, ddr_pall  out  NUM_SLOTS each  per-slot command strobes/flags
ddr_bg  out  NUM_SLOTS*BG_WIDTH  per-slot bank group
ddr_bank  out  NUM_SLOTS*BANK_WIDTH  per-slot bank
ddr_col  out  NUM_SLOTS*COL_WIDTH  per-slot column
ddr_row  out  NUM_SLOTS*ROW_WIDTH  per-slot row
fifo_level  out  $clog2(FIFO_DEPTH)+1  words held
underflow_cnt  out  CNT_WIDTH  cycles starved while enabled (saturating)
issued_cnt  out  CNT_WIDTH  non-WAIT words issued (saturating)
latest_instr_id  out  3  opcode of slot 0 of the last issued word

Behaviour:
- Slot format: F = 3+BANK_WIDTH+BG_WIDTH.
  - opcode [2:0]; bank [3 +: BANK_WIDTH]; bg [3+BANK_WIDTH +: BG_WIDTH].
  - row [F +: ROW_WIDTH]; col [F +: COL_WIDTH]; ap [F+COL_WIDTH]; half_bl [F+COL_WIDTH+1]; pall [F]; wait count [3 +: WAIT_WIDTH].
  - Elaboration error if F+ROW_WIDTH, F+COL_WIDTH+2 or 3+WAIT_WIDTH exceeds SLOT_WIDTH.
- Opcodes: 0 NOP, 1 PRE, 2 ACT, 3 RD, 4 WR, 5 REF, 6 WAIT, 7 ZQ.
  - Exactly one strobe per slot.
  - bank/bg/row/col are passed for every opcode.
  - ap/half_bl are driven only for RD/WR, else 0.
  - pall is driven only for PRE, else 0.
- Reset: every ddr_* output, latest_instr_id, both counters and fifo_level are 0. FIFO is emptied. State = RUN, wait counter = 0.
- Input: S_AXIS_TREADY = (fifo_level < FIFO_DEPTH), derived from the registered level only.
  - A push occurs on TVALID & TREADY.
  - When full, no push occurs even if a pop happens in the same cycle.
- FIFO:
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: RUN, WAIT.
  - RUN, enable=1, FIFO non-empty: pop the head word.
    - If slot 0 opcode is 6 with count N: go to WAIT with counter = max(N,1)-1. Outputs show the idle word. This is the first idle cycle.
    - Otherwise, decode all slots and register to outputs (1-cycle latency from pop). issued_cnt += 1. latest_instr_id = slot 0 opcode.
    - Opcode 6 in slots 1..NUM_SLOTS-1 decodes as NOP.
  - RUN, enable=1, FIFO empty: idle word; underflow_cnt += 1.
  - RUN, enable=0: idle word, no pop, no count.
  - WAIT: idle word each cycle.
    - While enable=1, the counter decrements; at 0, return to RUN. Total idle cycles = max(N,1).
    - enable=0 freezes the counter.
- Idle word: ddr_nop all ones, all other outputs 0.
- Latency: a word pushed at cycle t into an empty FIFO with enable=1 is popped at t+1 and appears on outputs at t+2. Back-to-back words issue on consecutive cycles.
- Counters saturate at all-ones.
- Reset mid-WAIT or mid-stream discards the FIFO and counter, and returns to RUN.

Test Plan:
1. Reset, then push one word: slot0 ACT bank=1 bg=2 row=0x1ABCD; slot1 RD col=0x155 ap=1; slots2-3 NOP. Response at t+2: ddr_act=0001, ddr_read=0010, ddr_ap=0010, ddr_nop=1100, row slot0=0x1ABCD, col slot1=0x155, issued_cnt=1.
2. enable=0, push 17 words. Response: TREADY drops after 16 pushes, fifo_level=16. Raise enable: 16 words issue on consecutive cycles in push order; TREADY reasserts one cycle after the first pop.
3. Queue words A, WAIT N=3, B with enable=1. Response: A, then exactly 3 idle cycles, then B. issued_cnt=2. WAIT N=0 gives 1 idle cycle.
4. enable=1 with the FIFO empty for 5 cycles. Response: ddr_nop=1111 each cycle, underflow_cnt=5.
5. Drop enable for 4 cycles mid-WAIT N=5. Response: 9 idle cycles total before the next word.
6. Assert rst with 6 words queued during WAIT. Response: next cycle all outputs 0, fifo_level=0, TREADY=1. The next pushed word issues with 2-cycle latency.
